// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module : cmp_pkg
// Brief  : State encoding and offset-binary helpers for signed_sar_search.
// Rev    : 1.0
// ============================================================================
package cmp_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] VERIFY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SEARCH = SEARCH,
    ST_VERIFY = VERIFY,
    ST_DONE   = DONE
  } state_e;

  localparam int MAX_WIDTH = 16;

  // XOR with this mask converts between two's complement and offset binary.
  function automatic logic [MAX_WIDTH-1:0] msb_mask(input int width);
    logic [MAX_WIDTH-1:0] one;
    one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    return one << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/signed_sar_search.sv
`default_nettype none
// ============================================================================
// Module : signed_sar_search
// Brief  : Successive-approximation probe engine that recovers a signed
//          target through a signed less-than comparator.
// Rev    : 1.0
// ============================================================================
module signed_sar_search
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             lt,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int                   PW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [MAX_WIDTH-1:0] MASK_FULL = msb_mask(WIDTH);
  localparam logic [WIDTH-1:0]     MASK      = MASK_FULL[WIDTH-1:0];
  localparam logic [PW-1:0]        PTR_TOP   = PW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] acc_upd;
  logic [WIDTH-1:0] next_bit;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ptr_d    = ptr_q;
    probe_d  = probe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    trial    = acc_q | (ONE << ptr_q);
    acc_upd  = lt ? trial : acc_q;
    next_bit = ONE << (ptr_q - 1'b1);

    case (state_q)
      ST_IDLE: begin
        probe_d = '0;
        busy_d  = 1'b0;
        if (start) begin
          acc_d   = '0;
          ptr_d   = PTR_TOP;
          busy_d  = 1'b1;
          probe_d = (ONE << PTR_TOP) ^ MASK;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        acc_d = acc_upd;
        if (ptr_q == '0) begin
          probe_d = acc_upd ^ MASK;
          state_d = ST_VERIFY;
        end else begin
          ptr_d   = ptr_q - 1'b1;
          probe_d = (acc_upd | next_bit) ^ MASK;
        end
      end
      ST_VERIFY: begin
        // acc is the largest offset strictly below the target, or 0 if none;
        // the final compare resolves the 0-versus-1 ambiguity.
        result_d = (lt ? (acc_q + ONE) : acc_q) ^ MASK;
        probe_d  = '0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        probe_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      ptr_q    <= '0;
      probe_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ptr_q    <= ptr_d;
      probe_q  <= probe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_sar_search.sv
`default_nettype none
// ============================================================================
// Module : tb_signed_sar_search
// Brief  : Scoreboard bench for signed_sar_search with a behavioural signed
//          less-than comparator answering the probes.
// Rev    : 1.0
// ============================================================================
module tb_signed_sar_search;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         lt;
  logic [W-1:0] target;
  logic [W-1:0] probe;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  // Responder: signed comparator with A = probe, B = target.
  assign lt = ($signed(probe) < $signed(target));

  signed_sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .lt     (lt),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           done_cnt = 0;
  int           last_done_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Output monitor: scores every done pulse against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", int'(result), int'(exp_v));
        end
      end
    end
  end

  task automatic wait_done();
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < 20) begin
      step();
      k++;
    end
    check("done_timeout", int'(done_cnt != n0), 1);
  endtask

  // One search from IDLE; pr packs the five expected probes, first in the MSBs.
  task automatic do_search(input logic [W-1:0] t, input logic [19:0] pr,
                           input bit repulse);
    int s;
    int n0;
    target = t;
    start  = 1'b1;
    exp_q.push_back(t);
    n0 = done_cnt;
    step();
    s = cyc;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("probe%0d_t%0d", i, $signed(t)), int'(probe),
            int'(pr[(4-i)*4 +: 4]));
      if (i == 0 || i == 4) check("busy_hi", int'(busy), 1);
      start = repulse && (i == 1 || i == 3);
      step();
    end
    start = 1'b0;
    check("done_pulse", int'(done), 1);
    check("busy_lo_done", int'(busy), 0);
    check("probe_zero_done", int'(probe), 0);
    check("latency", last_done_cyc - s + 1, 6);
    check("done_count", done_cnt - n0, 1);
    step();
    check("done_one_cycle", int'(done), 0);
    if (repulse) begin
      repeat (8) step();
      check("repulse_single_done", done_cnt - n0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    int n0;
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    step();
    step();
    check("rst_probe", int'(probe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    reset = 1'b0;
    step();

    do_search(4'sd5,  20'h04654, 1'b0);
    do_search(-4'sd8, 20'h0CA98, 1'b0);
    do_search(4'sd7,  20'h04676, 1'b0);
    do_search(-4'sd3, 20'h0CEDC, 1'b1);

    // Back-to-back sweep with start held high; next target set in DONE.
    start  = 1'b1;
    target = W'(-8);
    exp_q.push_back(target);
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      wait_done();
      if (k > 0) check("period", last_done_cyc - prev, 7);
      prev = last_done_cyc;
      if (k < 15) begin
        target = W'(k - 7);
        exp_q.push_back(target);
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) step();

    // Abort in cycle 3 of a search: outputs clear immediately, no done.
    n0     = done_cnt;
    target = 4'sd5;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort_probe", int'(probe), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    step();
    step();
    reset = 1'b0;
    repeat (8) step();
    check("abort_no_done", done_cnt - n0, 0);

    do_search(4'sd2, 20'h04211, 1'b0);

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
